// File: rtl/nsa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nsa_pkg
//  Description : Shared types and helpers for the nibble-serial adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package nsa_pkg;

    // Bits handled by the ripple cell per step
    localparam int c_nib_bits = 4;

    // Controller state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } nsa_state_t;

    // Number of nibble steps needed for a WIDTH-bit addition
    function automatic int nib_count(input int width);
        return width / c_nib_bits;
    endfunction

    // Nibble index counter width; never narrower than one bit
    function automatic int idx_width(input int nib);
        return (nib <= 1) ? 1 : $clog2(nib);
    endfunction

endpackage : nsa_pkg
`default_nettype wire

// File: rtl/full_adder_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_4bit
//  Description : 4-bit ripple-carry adder cell built from full-adder bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [4:0] w_carry;

    assign w_carry[0] = i_cin;

    // One full-adder bit per position, carry rippling upward
    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
        assign o_sum[gi]       = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
        assign w_carry[gi + 1] = (i_a[gi] & i_b[gi]) |
                                 (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
    end

    assign o_cout = w_carry[4];

endmodule : full_adder_4bit
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_adder
//  Description : WIDTH-bit adder that streams operands one nibble per clock
//                through a single 4-bit ripple cell, LSB nibble first, with
//                the carry held in a register between steps. Valid/ready on
//                both the operand and the result side.
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_nib   = nib_count(WIDTH);
    localparam int c_idx_w = idx_width(c_nib);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nib - 1);

    // Reject widths the nibble datapath cannot cover exactly
    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    nsa_state_t         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_ovf;
    logic [c_idx_w-1:0] r_idx;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [c_idx_w+1:0] w_base;
    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;
    logic [3:0]         w_cell_sum;
    logic               w_cell_cout;
    logic               w_last;

    // Bit offset of the nibble currently being processed
    assign w_base  = {r_idx, 2'b00};
    assign w_a_nib = r_a[w_base +: 4];
    assign w_b_nib = r_b[w_base +: 4];
    assign w_last  = (r_idx == c_last_idx);

    full_adder_4bit u_cell (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .o_sum  (w_cell_sum),
        .o_cout (w_cell_cout)
    );

    // Controller, operand/sum/carry registers and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // cin enters through the carry register so nibble 0
                        // uses the same path as every later nibble
                        r_a        <= a;
                        r_b        <= b;
                        r_carry    <= cin;
                        r_sum      <= '0;
                        r_ovf      <= 1'b0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ADD;
                    end
                end
                ADD: begin
                    r_sum[w_base +: 4] <= w_cell_sum;
                    r_carry            <= w_cell_cout;
                    if (w_last) begin
                        // The top nibble's MSB is the result sign bit
                        r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                       (w_cell_sum[3] != r_a[WIDTH-1]);
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_carry;
    assign ovf       = r_ovf;

endmodule : nibble_serial_adder
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_serial_adder
//  Description : Directed self-checking bench for nibble_serial_adder with a
//                16-bit and a 4-bit instance sharing clock and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    logic        in_valid4;
    logic        in_ready4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        cin4;
    logic        out_valid4;
    logic        out_ready4;
    logic [3:0]  sum4;
    logic        cout4;
    logic        ovf4;

    int checks;
    int failures;

    nibble_serial_adder #(.WIDTH(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    nibble_serial_adder #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .cout      (cout4),
        .ovf       (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete 16-bit addition with out_ready held high
    task automatic do_add(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tc, input logic [15:0] es, input logic ec, input logic eo);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~ta; b = ~tb_v; cin = ~tc;
        chk({tag, "_busy"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd4);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        @(posedge clk); #1;
        chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    logic [15:0] ba [3];
    logic [15:0] bb [3];
    logic [15:0] bs [3];

    initial begin
        int n;
        int sent;
        int got;
        int cyc;
        int last_cyc;
        logic acc;
        logic prev_ready;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b1;
        a4 = '0; b4 = '0; cin4 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_add("basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_add("ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_add("cin",     16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        do_add("posovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_add("negovf",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Backpressure: result must hold while the consumer stalls
        out_ready = 1'b0;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("bp_latency", 32'(n), 32'd4);
        for (int i = 0; i < 5; i++) begin
            a = 16'(i * 16'h1357); b = ~a; in_valid = i[0];
            @(posedge clk); #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_sum", 32'(sum), 32'h3333);
            chk("bp_cout", 32'(cout), 32'd0);
            chk("bp_ovf", 32'(ovf), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", 32'(out_valid), 32'd0);
        chk("bp_idle", 32'(in_ready), 32'd1);

        // Reset in the second ADD cycle discards the partial result
        a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_cout", 32'(cout), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("mid_rst_no_result", 32'(out_valid), 32'd0);
        end
        do_add("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

        // Back-to-back operand stream with in_valid held high
        ba[0] = 16'h0001; bb[0] = 16'h0002; bs[0] = 16'h0003;
        ba[1] = 16'h00FF; bb[1] = 16'h0001; bs[1] = 16'h0100;
        ba[2] = 16'hABCD; bb[2] = 16'h1111; bs[2] = 16'hBCDE;
        sent = 0; got = 0; cyc = 0; last_cyc = 0;
        a = ba[0]; b = bb[0]; cin = 1'b0; in_valid = 1'b1;
        prev_ready = in_ready;
        while (got < 3 && cyc < 60) begin
            @(posedge clk);
            acc = prev_ready && in_valid;
            #1;
            cyc++;
            if (acc) begin
                sent++;
                if (sent < 3) begin
                    a = ba[sent]; b = bb[sent];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                chk("b2b_sum", 32'(sum), 32'(bs[got]));
                if (got > 0) chk("b2b_spacing", 32'(cyc - last_cyc), 32'd6);
                last_cyc = cyc;
                got++;
            end
            prev_ready = in_ready;
        end
        in_valid = 1'b0;
        chk("b2b_count", 32'(got), 32'd3);

        // 4-bit build: single nibble step
        @(posedge clk); #1;
        chk("w4_ready", 32'(in_ready4), 32'd1);
        a4 = 4'h9; b4 = 4'h8; cin4 = 1'b0; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        chk("w4_valid_early", 32'(out_valid4), 32'd0);
        @(posedge clk); #1;
        chk("w4_valid", 32'(out_valid4), 32'd1);
        chk("w4_sum", 32'(sum4), 32'h1);
        chk("w4_cout", 32'(cout4), 32'd1);
        chk("w4_ovf", 32'(ovf4), 32'd1);
        @(posedge clk); #1;
        chk("w4_vld_drop", 32'(out_valid4), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_nibble_serial_adder
`default_nettype wire

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder that streams two operands through a single 4-bit ripple adder cell, one nibble per clock, LSB nibble first, with the carry registered between nibbles. Sits between an operand-producing stage (valid/ready source) and a result consumer (valid/ready sink). Trades latency for area when wide additions are needed.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4. Any other value is an elaboration error.
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand bundle (a, b, cin) valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B
- cin  input  1  carry into nibble 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  A + B + cin, modulo 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  signed overflow: a[MSB]==b[MSB] and sum[MSB]!=a[MSB]

## Operation
- NIB = WIDTH/4 nibble steps per addition.
- States: IDLE, ADD, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, cin into operand registers, clear nibble index to 0, clear sum register, go to ADD.
- ADD: adder cell gets a_reg[4i+3:4i], b_reg[4i+3:4i], carry_reg (cin latched for i=0). Each cycle write the cell sum into sum_reg[4i+3:4i] and its carry out into carry_reg; increment i. When i==NIB-1, go to DONE after that write.
- DONE: out_valid=1; sum, cout (=carry_reg), ovf stable. On out_ready, go to IDLE.
- in_ready is 1 only in IDLE; in_valid in ADD/DONE is ignored (no accept, operands not sampled).
- out_valid holds with stable data while out_ready is low, indefinitely.
- Operand changes after accept have no effect.
- NIB=1: ADD lasts one cycle; index counter width is max(1, clog2(NIB)).

## Timing
- Reset (async assert, any state, including mid-ADD): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, index=0, carry_reg=0. An in-flight addition is discarded; no partial result is ever presented.
- Reset deassertion takes effect at the next rising edge; first accept possible on that edge.
- Latency: accept at edge k, out_valid rises after edge k+NIB.
- Throughput: at most one addition per NIB+2 cycles. Handshake at edge m gives in_ready=1 after edge m, and the next accept can occur at edge m+1.
- All outputs are registered or decoded from state only. No combinational path from in_valid/out_ready to any output.

## Structure
- Shared package nsa_pkg: state enum (IDLE, ADD, DONE); constant function nib_count(WIDTH); index width helper.
- One sub-module: full_adder_4bit, the team's existing 4-bit ripple cell. Instantiate it exactly once, with the nibble mux feeding it and carry_reg on its carry-in.
- Top holds the FSM, operand/sum/carry registers, nibble index counter, and the WIDTH legality check.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1 -> after 4 cycles sum=0x5555, cout=0, ovf=0; out_valid high exactly one cycle.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples across all nibbles). Also a=0x0000, b=0x0000, cin=1 -> sum=0x0001.
- a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout, ovf stable. Toggling a/b/in_valid during this time -> no accept, in_ready=0.
- Assert rst_n low during the second ADD cycle -> all outputs zero immediately, state IDLE. A new add after release (0x0F0F+0x00F1) -> sum=0x1000, correct.
- Back-to-back: in_valid held high with 3 operand sets, out_ready=1 -> results in order, each NIB+2 cycles apart. WIDTH=4 build: 0x9+0x8 -> sum=0x1, cout=1, ovf=1, out_valid 1 cycle after accept.
